// File: rtl/chacha_pkg.sv
// Shared constants, state typedefs and index tables for the iterative ChaCha block engine.
package chacha_pkg;

  localparam logic [31:0] SIGMA0 = 32'h61707865;
  localparam logic [31:0] SIGMA1 = 32'h3320646E;
  localparam logic [31:0] SIGMA2 = 32'h79622D32;
  localparam logic [31:0] SIGMA3 = 32'h6B206574;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    OUT   = 2'd3
  } state_e;

  // 16 words of 32 bits; word i lives at [32i+31:32i].
  typedef logic [15:0][31:0] state_t;

  // Entry [lane*4+pos] is the state word feeding quarter-round 'lane' at operand 'pos' (a,b,c,d).
  localparam logic [15:0][3:0] COL_IDX = {
    4'd15, 4'd11, 4'd7, 4'd3,
    4'd14, 4'd10, 4'd6, 4'd2,
    4'd13, 4'd9,  4'd5, 4'd1,
    4'd12, 4'd8,  4'd4, 4'd0
  };
  localparam logic [15:0][3:0] DIAG_IDX = {
    4'd14, 4'd9,  4'd4, 4'd3,
    4'd13, 4'd8,  4'd7, 4'd2,
    4'd12, 4'd11, 4'd6, 4'd1,
    4'd15, 4'd10, 4'd5, 4'd0
  };

  function automatic logic [31:0] rotl32(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic state_t init_state(input logic [255:0] key, input logic [31:0] ctr,
                                        input logic [95:0] nonce);
    state_t s;
    s[0] = SIGMA0;
    s[1] = SIGMA1;
    s[2] = SIGMA2;
    s[3] = SIGMA3;
    for (int i = 0; i < 8; i++) s[4+i] = key[32*i +: 32];
    s[12] = ctr;
    for (int i = 0; i < 3; i++) s[13+i] = nonce[32*i +: 32];
    return s;
  endfunction

endpackage

// File: rtl/chacha_qr.sv
// Purely combinational ChaCha quarter round on four 32-bit words.
module chacha_qr
  import chacha_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] c_i,
  input  logic [31:0] d_i,
  output logic [31:0] a_o,
  output logic [31:0] b_o,
  output logic [31:0] c_o,
  output logic [31:0] d_o
);

  logic [31:0] a1, b1, c1, d1;

  assign a1  = a_i + b_i;
  assign d1  = rotl32(d_i ^ a1, 16);
  assign c1  = c_i + d1;
  assign b1  = rotl32(b_i ^ c1, 12);
  assign a_o = a1 + b1;
  assign d_o = rotl32(d1 ^ a_o, 8);
  assign c_o = c1 + d_o;
  assign b_o = rotl32(b1 ^ c_o, 7);

endmodule

// File: rtl/chacha_block_engine.sv
// Iterative ChaCha block function: one half-round per cycle through a shared 4-lane
// quarter-round bank, feed-forward add, one 512-bit keystream block per counter value.
module chacha_block_engine
  import chacha_pkg::*;
#(
  parameter int ROUNDS    = 20,
  parameter int BLK_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [255:0]         in_key,
  input  logic [95:0]          in_nonce,
  input  logic [31:0]          in_ctr,
  input  logic [BLK_CNT_W-1:0] in_nblk,
  input  logic                 abort,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [511:0]         out_ks,
  output logic [31:0]          out_ctr,
  output logic                 out_last,
  output logic                 ctr_wrap,
  output state_e               dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // a producer holding valid keeps its payload stable until that edge.

  localparam int RND_W = $clog2(ROUNDS);
  localparam logic [RND_W-1:0] LAST_RND = RND_W'(ROUNDS - 1);
  localparam logic [BLK_CNT_W-1:0] ONE_BLK = BLK_CNT_W'(1);

  state_e               state_q, state_d;
  logic [RND_W-1:0]     rnd_q, rnd_d;
  state_t               work_q, work_d;
  state_t               orig_q, orig_d;
  logic [BLK_CNT_W-1:0] rem_q, rem_d;
  logic                 out_valid_q, out_valid_d;
  state_t               out_ks_q, out_ks_d;
  logic [31:0]          out_ctr_q, out_ctr_d;
  logic                 out_last_q, out_last_d;
  logic                 ctr_wrap_q, ctr_wrap_d;

  logic [3:0][3:0][31:0] qr_in, qr_out;
  state_t                round_res;
  state_t                reload_st;
  logic [31:0]           ctr_inc;

  // Odd half-rounds use the diagonals; the same bank serves both.
  always_comb begin
    for (int l = 0; l < 4; l++) begin
      for (int p = 0; p < 4; p++) begin
        qr_in[l][p] = work_q[rnd_q[0] ? DIAG_IDX[l*4+p] : COL_IDX[l*4+p]];
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_qr
    chacha_qr u_qr (
      .a_i(qr_in[g][0]),
      .b_i(qr_in[g][1]),
      .c_i(qr_in[g][2]),
      .d_i(qr_in[g][3]),
      .a_o(qr_out[g][0]),
      .b_o(qr_out[g][1]),
      .c_o(qr_out[g][2]),
      .d_o(qr_out[g][3])
    );
  end

  always_comb begin
    round_res = work_q;
    for (int l = 0; l < 4; l++) begin
      for (int p = 0; p < 4; p++) begin
        round_res[rnd_q[0] ? DIAG_IDX[l*4+p] : COL_IDX[l*4+p]] = qr_out[l][p];
      end
    end
  end

  // Key, nonce and counter live in the original state, so the next block is a word-12 swap.
  assign ctr_inc = orig_q[12] + 32'd1;
  always_comb begin
    reload_st     = orig_q;
    reload_st[12] = ctr_inc;
  end

  always_comb begin
    state_d     = state_q;
    rnd_d       = rnd_q;
    work_d      = work_q;
    orig_d      = orig_q;
    rem_d       = rem_q;
    out_valid_d = out_valid_q;
    out_ks_d    = out_ks_q;
    out_ctr_d   = out_ctr_q;
    out_last_d  = out_last_q;
    ctr_wrap_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = init_state(in_key, in_ctr, in_nonce);
          orig_d  = init_state(in_key, in_ctr, in_nonce);
          rem_d   = (in_nblk == '0) ? ONE_BLK : in_nblk;
          rnd_d   = '0;
          state_d = ROUND;
        end
      end
      ROUND: begin
        work_d = round_res;
        rnd_d  = rnd_q + 1'b1;
        if (rnd_q == LAST_RND) state_d = FINAL;
      end
      FINAL: begin
        for (int i = 0; i < 16; i++) out_ks_d[i] = work_q[i] + orig_q[i];
        out_ctr_d   = orig_q[12];
        out_last_d  = (rem_q == ONE_BLK);
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (rem_q == ONE_BLK) begin
            state_d = IDLE;
          end else begin
            rem_d      = rem_q - ONE_BLK;
            work_d     = reload_st;
            orig_d     = reload_st;
            ctr_wrap_d = (orig_q[12] == 32'hFFFF_FFFF);
            rnd_d      = '0;
            state_d    = ROUND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort overrides everything, including a simultaneous output handshake.
    if (abort && (state_q != IDLE)) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      ctr_wrap_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      rnd_q       <= '0;
      work_q      <= '0;
      orig_q      <= '0;
      rem_q       <= '0;
      out_valid_q <= 1'b0;
      out_ks_q    <= '0;
      out_ctr_q   <= '0;
      out_last_q  <= 1'b0;
      ctr_wrap_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rnd_q       <= rnd_d;
      work_q      <= work_d;
      orig_q      <= orig_d;
      rem_q       <= rem_d;
      out_valid_q <= out_valid_d;
      out_ks_q    <= out_ks_d;
      out_ctr_q   <= out_ctr_d;
      out_last_q  <= out_last_d;
      ctr_wrap_q  <= ctr_wrap_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = out_valid_q;
  assign out_ks      = out_ks_q;
  assign out_ctr     = out_ctr_q;
  assign out_last    = out_last_q;
  assign ctr_wrap    = ctr_wrap_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_chacha_block_engine.sv
// Bench for chacha_block_engine: a 20-round and an 8-round instance, expected-block queues
// filled at job issue and drained by per-instance monitors on every new block presentation.
module tb_chacha_block_engine;
  import chacha_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_valid8, abort, out_ready;
  logic [255:0] in_key;
  logic [95:0]  in_nonce;
  logic [31:0]  in_ctr;
  logic [7:0]   in_nblk;

  logic         in_ready, out_valid, out_last, ctr_wrap;
  logic [511:0] out_ks;
  logic [31:0]  out_ctr;
  state_e       dbg_state;

  logic         in_ready8, out_valid8, out_last8, ctr_wrap8;
  logic [511:0] out_ks8;
  logic [31:0]  out_ctr8;
  state_e       dbg_state8;
  logic         out_ready8 = 1'b1;
  logic         abort8 = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int wrap_cnt = 0;
  int blocks_seen = 0;

  logic [544:0] exp_q[$];
  logic [544:0] exp8_q[$];

  always #5 clk = ~clk;

  chacha_block_engine #(.ROUNDS(20), .BLK_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_key(in_key), .in_nonce(in_nonce), .in_ctr(in_ctr), .in_nblk(in_nblk),
    .abort(abort), .out_valid(out_valid), .out_ready(out_ready), .out_ks(out_ks),
    .out_ctr(out_ctr), .out_last(out_last), .ctr_wrap(ctr_wrap), .dbg_state_o(dbg_state)
  );

  chacha_block_engine #(.ROUNDS(8), .BLK_CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_key(in_key), .in_nonce(in_nonce), .in_ctr(in_ctr), .in_nblk(in_nblk),
    .abort(abort8), .out_valid(out_valid8), .out_ready(out_ready8), .out_ks(out_ks8),
    .out_ctr(out_ctr8), .out_last(out_last8), .ctr_wrap(ctr_wrap8), .dbg_state_o(dbg_state8)
  );

  // ---------------- reference model ----------------
  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [127:0] qr_ref(input logic [31:0] a, b, c, d);
    a = a + b; d = rotl(d ^ a, 16);
    c = c + d; b = rotl(b ^ c, 12);
    a = a + b; d = rotl(d ^ a, 8);
    c = c + d; b = rotl(b ^ c, 7);
    return {d, c, b, a};
  endfunction

  function automatic logic [511:0] chacha_ref(input logic [255:0] k, input logic [95:0] n,
                                              input logic [31:0] c, input int rounds);
    logic [31:0]  s[16];
    logic [31:0]  x[16];
    logic [511:0] r;
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4+i] = k[32*i +: 32];
    s[12] = c;
    for (int i = 0; i < 3; i++) s[13+i] = n[32*i +: 32];
    x = s;
    for (int i = 0; i < rounds / 2; i++) begin
      {x[12], x[8],  x[4], x[0]} = qr_ref(x[0], x[4], x[8],  x[12]);
      {x[13], x[9],  x[5], x[1]} = qr_ref(x[1], x[5], x[9],  x[13]);
      {x[14], x[10], x[6], x[2]} = qr_ref(x[2], x[6], x[10], x[14]);
      {x[15], x[11], x[7], x[3]} = qr_ref(x[3], x[7], x[11], x[15]);
      {x[15], x[10], x[5], x[0]} = qr_ref(x[0], x[5], x[10], x[15]);
      {x[12], x[11], x[6], x[1]} = qr_ref(x[1], x[6], x[11], x[12]);
      {x[13], x[8],  x[7], x[2]} = qr_ref(x[2], x[7], x[8],  x[13]);
      {x[14], x[9],  x[4], x[3]} = qr_ref(x[3], x[4], x[9],  x[14]);
    end
    for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i] + s[i];
    return r;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Queue 'count' blocks of a job of 'nblk_eff' blocks starting at counter c0.
  task automatic push_blocks(input logic [31:0] c0, input int nblk_eff, input int count);
    logic [31:0] c;
    for (int i = 0; i < count; i++) begin
      c = c0 + 32'(i);
      exp_q.push_back({chacha_ref(in_key, in_nonce, c, 20), c, (i == nblk_eff - 1)});
    end
  endtask

  // ---------------- monitors ----------------
  logic         presented = 1'b0;
  logic         hold_v = 1'b0;
  logic [544:0] snap;

  always @(negedge clk) begin
    logic [544:0] e;
    if (ctr_wrap) wrap_cnt++;
    if (out_valid && !presented) begin
      blocks_seen++;
      if (exp_q.size() == 0) begin
        chk("unexpected_block_ctr", out_ctr, 512'h0);
        chk("unexpected_block_valid", out_valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        chk("blk_ks", out_ks, e[544:33]);
        chk("blk_ctr", out_ctr, e[32:1]);
        chk("blk_last", out_last, e[0]);
      end
      presented = 1'b1;
    end else if (out_valid && hold_v) begin
      chk("stall_stable", {out_ks, out_ctr, out_last}, snap);
    end
    hold_v = out_valid && !out_ready;
    snap   = {out_ks, out_ctr, out_last};
    if (!out_valid || out_ready) presented = 1'b0;
  end

  logic presented8 = 1'b0;
  always @(negedge clk) begin
    logic [544:0] e;
    if (out_valid8 && !presented8) begin
      if (exp8_q.size() == 0) begin
        chk("unexpected_block8", out_valid8, 1'b0);
      end else begin
        e = exp8_q.pop_front();
        chk("blk8_ks", out_ks8, e[544:33]);
        chk("blk8_ctr", out_ctr8, e[32:1]);
        chk("blk8_last", out_last8, e[0]);
      end
      presented8 = 1'b1;
    end
    if (!out_valid8 || out_ready8) presented8 = 1'b0;
  end

  // ---------------- drivers ----------------
  task automatic start_job(input bit sel8, input logic [31:0] c, input logic [7:0] n);
    @(posedge clk);
    #1;
    chk("in_ready_before_job", sel8 ? in_ready8 : in_ready, 1'b1);
    in_ctr  = c;
    in_nblk = n;
    if (sel8) in_valid8 = 1'b1; else in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_valid8 = 1'b0;
  endtask

  // Counts negedges from the last accept/handshake edge until out_valid is seen (bounded).
  task automatic wait_valid(input bit sel8, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(sel8 ? out_valid8 : out_valid) && n < 200);
  endtask

  task automatic count_valid(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (out_valid) n++;
    end
  endtask

  initial begin
    int n, w0, b0;
    rst = 1'b0; in_valid = 1'b0; in_valid8 = 1'b0; abort = 1'b0; out_ready = 1'b1;
    in_ctr = '0; in_nblk = '0; in_nonce = '0; in_key = '0;
    for (int i = 0; i < 32; i++) in_key[8*i +: 8] = 8'(i);
    in_nonce = {32'h00000000, 32'h4A000000, 32'h09000000};

    // Reset
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_ks", out_ks, 512'h0);
    chk("rst_out_ctr", out_ctr, 32'h0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_ctr_wrap", ctr_wrap, 1'b0);

    // RFC 8439 block function vector
    push_blocks(32'd1, 1, 1);
    start_job(1'b0, 32'd1, 8'd1);
    wait_valid(1'b0, n);
    chk("rfc_latency", n, 22);
    chk("rfc_word0", out_ks[31:0], 32'hE4E7F110);
    chk("rfc_word1", out_ks[63:32], 32'h15593BD1);
    chk("rfc_word15", out_ks[511:480], 32'h4E3C50A2);
    chk("rfc_last", out_last, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rfc_in_ready_back", in_ready, 1'b1);

    // Three blocks, block 2 stalled for 5 cycles
    push_blocks(32'd1, 3, 3);
    start_job(1'b0, 32'd1, 8'd3);
    wait_valid(1'b0, n);
    chk("mb_latency1", n, 22);
    chk("mb_in_ready_busy", in_ready, 1'b0);
    @(posedge clk); #1 out_ready = 1'b0;
    wait_valid(1'b0, n);
    chk("mb_spacing2", n, 22);
    repeat (5) @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk); #1;
    wait_valid(1'b0, n);
    chk("mb_spacing3", n, 22);
    chk("mb_in_ready_b3", in_ready, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mb_in_ready_after", in_ready, 1'b1);

    // Counter wrap
    w0 = wrap_cnt;
    push_blocks(32'hFFFF_FFFF, 2, 2);
    start_job(1'b0, 32'hFFFF_FFFF, 8'd2);
    wait_valid(1'b0, n);
    chk("wrap_latency1", n, 22);
    chk("wrap_no_pulse_yet", wrap_cnt - w0, 0);
    @(posedge clk); #1;
    wait_valid(1'b0, n);
    chk("wrap_latency2", n, 22);
    @(posedge clk); #1;
    repeat (2) @(negedge clk);
    chk("wrap_pulse_count", wrap_cnt - w0, 1);

    // Abort during half-round 7
    b0 = blocks_seen;
    start_job(1'b0, 32'd5, 8'd1);
    repeat (7) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_rnd_in_ready", in_ready, 1'b1);
    count_valid(40, n);
    chk("abort_rnd_no_valid", n, 0);
    chk("abort_rnd_no_block", blocks_seen - b0, 0);

    // Abort together with the handshake of block 1 of 4
    push_blocks(32'd10, 4, 1);
    start_job(1'b0, 32'd10, 8'd4);
    wait_valid(1'b0, n);
    chk("abort_hs_latency", n, 22);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    count_valid(60, n);
    chk("abort_hs_no_block2", n, 0);
    chk("abort_hs_in_ready", in_ready, 1'b1);

    // nblk == 0 behaves as a single block
    b0 = blocks_seen;
    push_blocks(32'd20, 1, 1);
    start_job(1'b0, 32'd20, 8'd0);
    wait_valid(1'b0, n);
    chk("nblk0_latency", n, 22);
    @(posedge clk); #1;
    count_valid(40, n);
    chk("nblk0_one_block", blocks_seen - b0, 1);
    chk("nblk0_in_ready", in_ready, 1'b1);

    // Synchronous reset while a block is held in OUT
    out_ready = 1'b0;
    push_blocks(32'd30, 2, 1);
    start_job(1'b0, 32'd30, 8'd2);
    wait_valid(1'b0, n);
    chk("rstout_latency", n, 22);
    #2 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rstout_out_valid", out_valid, 1'b0);
    chk("rstout_out_ks", out_ks, 512'h0);
    chk("rstout_out_ctr", out_ctr, 32'h0);
    chk("rstout_out_last", out_last, 1'b0);
    chk("rstout_ctr_wrap", ctr_wrap, 1'b0);
    chk("rstout_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;

    // 8-round build against the ChaCha8 model
    exp8_q.push_back({chacha_ref(in_key, in_nonce, 32'd7, 8), 32'd7, 1'b1});
    start_job(1'b1, 32'd7, 8'd1);
    wait_valid(1'b1, n);
    chk("r8_latency", n, 10);
    repeat (5) @(negedge clk);
    chk("r8_in_ready_back", in_ready8, 1'b1);

    chk("exp_q_drained", exp_q.size(), 0);
    chk("exp8_q_drained", exp8_q.size(), 0);
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
